// File: rtl/weight_preload_sequencer_pkg.sv
// Shared constants and state encoding for the systolic-array weight pre-load sequencer.
package weight_preload_sequencer_pkg;
  localparam int ARRAY_N    = 8;
  localparam int WEIGHT_W   = 8;
  localparam int ADDR_W     = 6;
  localparam int TILE_SIZE  = ARRAY_N * ARRAY_N;
  localparam int FIFO_DEPTH = 4;
  localparam int DONE_DELAY = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    WAIT  = 2'd3
  } state_t;
endpackage

// File: rtl/weight_preload_sequencer_fifo.sv
// Small synchronous FIFO buffering host weight beats; no bypass, read data is combinational from storage.
module preload_fifo #(
  parameter int WIDTH = weight_preload_sequencer_pkg::WEIGHT_W,
  parameter int DEPTH = weight_preload_sequencer_pkg::FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/weight_preload_sequencer.sv
// Feeds one ARRAY_N x ARRAY_N weight tile from the host into the pre-load unit, in address order,
// then pulses done once the last weight has cleared the WPU pipeline.
module weight_preload_sequencer #(
  parameter int ARRAY_N    = weight_preload_sequencer_pkg::ARRAY_N,
  parameter int WEIGHT_W   = weight_preload_sequencer_pkg::WEIGHT_W,
  parameter int ADDR_W     = weight_preload_sequencer_pkg::ADDR_W,
  parameter int FIFO_DEPTH = weight_preload_sequencer_pkg::FIFO_DEPTH,
  parameter int DONE_DELAY = weight_preload_sequencer_pkg::DONE_DELAY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                host_valid,
  input  logic [WEIGHT_W-1:0] host_weight,
  output logic                host_ready,
  output logic [WEIGHT_W-1:0] weight,
  output logic [ADDR_W-1:0]   weight_addr,
  output logic                weight_valid,
  output logic                done,
  output logic                busy
);
  import weight_preload_sequencer_pkg::*;

  // Counters carry one extra bit so a full tile count is representable.
  localparam int              CW      = ADDR_W + 1;
  localparam logic [CW-1:0]   TILE    = CW'(ARRAY_N * ARRAY_N);
  localparam logic [CW-1:0]   TILE_M1 = CW'(ARRAY_N * ARRAY_N - 1);
  localparam int              DW      = $clog2(DONE_DELAY + 2);
  localparam logic [DW-1:0]   DLY     = DW'(DONE_DELAY);

  state_t               state, state_nx;
  logic [CW-1:0]        acc_cnt, iss_cnt;
  logic [DW-1:0]        dly_cnt;
  logic                 push, pop;
  logic                 fifo_full, fifo_empty;
  logic [WEIGHT_W-1:0]  fifo_dout;
  logic                 acc_last, iss_last, load_go;

  // host_ready depends only on registered state, never on host_valid.
  assign host_ready = (state == LOAD) && !fifo_full && (acc_cnt < TILE);
  assign push       = host_valid && host_ready;
  assign pop        = !fifo_empty && ((state == LOAD) || (state == DRAIN));
  assign busy       = (state != IDLE);
  assign acc_last   = push && (acc_cnt == TILE_M1);
  assign iss_last   = pop && (iss_cnt == TILE_M1);
  assign load_go    = (state == IDLE) && (state_nx == LOAD);

  preload_fifo #(
    .WIDTH (WEIGHT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (host_weight),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The 64th issue always trails the 64th accept (no bypass), so DRAIN is always visited.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && !done)    state_nx = LOAD;
      LOAD:    if (acc_last)          state_nx = DRAIN;
      DRAIN:   if (iss_last)          state_nx = WAIT;
      WAIT:    if (dly_cnt == DLY)    state_nx = IDLE;
      default:                        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      acc_cnt      <= '0;
      iss_cnt      <= '0;
      dly_cnt      <= '0;
      done         <= 1'b0;
      weight       <= '0;
      weight_addr  <= '0;
      weight_valid <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= (state == WAIT) && (state_nx == IDLE);
      if (load_go) begin
        acc_cnt <= '0;
        iss_cnt <= '0;
      end else begin
        if (push) acc_cnt <= acc_cnt + 1'b1;
        if (pop)  iss_cnt <= iss_cnt + 1'b1;
      end
      dly_cnt      <= (state == WAIT) ? dly_cnt + 1'b1 : '0;
      weight_valid <= pop;
      if (pop) begin
        weight      <= fifo_dout;
        weight_addr <= iss_cnt[ADDR_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_weight_preload_sequencer.sv
// Directed bench for weight_preload_sequencer with a scoreboard of accepted host beats.
module tb_weight_preload_sequencer;
  import weight_preload_sequencer_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic                host_valid = 1'b0;
  logic [WEIGHT_W-1:0] host_weight = '0;
  logic                host_ready;
  logic [WEIGHT_W-1:0] weight;
  logic [ADDR_W-1:0]   weight_addr;
  logic                weight_valid;
  logic                done;
  logic                busy;

  always #5 clk = ~clk;

  weight_preload_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .host_valid   (host_valid),
    .host_weight  (host_weight),
    .host_ready   (host_ready),
    .weight       (weight),
    .weight_addr  (weight_addr),
    .weight_valid (weight_valid),
    .done         (done),
    .busy         (busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [WEIGHT_W-1:0] sb_q[$];
  int exp_addr = 0;
  int n_vld_tile = 0;
  int sent = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_vld_cyc = 0;
  int done_cyc = 0;
  int w_mul = 1;
  int w_add = 1;
  logic rst_applied = 1'b1;
  logic [WEIGHT_W-1:0] prev_w = '0;
  logic [ADDR_W-1:0]   prev_a = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WEIGHT_W-1:0] wdata(input int i);
    return WEIGHT_W'(i * w_mul + w_add);
  endfunction

  // Sampled at the falling edge: output checks, then scoreboard push for the beat the next edge accepts.
  task automatic monitor();
    if (rst_applied) begin
      sb_q.delete();
      exp_addr = 0;
    end else if (weight_valid) begin
      chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) chk("weight", 32'(weight), 32'(sb_q.pop_front()));
      chk("weight_addr", 32'(weight_addr), exp_addr);
      if (exp_addr == TILE_SIZE - 1) last_vld_cyc = cyc;
      exp_addr = (exp_addr + 1) % TILE_SIZE;
      n_vld_tile++;
    end else begin
      chk("hold_weight", 32'(weight), 32'(prev_w));
      chk("hold_addr", 32'(weight_addr), 32'(prev_a));
    end
    prev_w = weight;
    prev_a = weight_addr;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rst && host_valid && host_ready) begin
      sb_q.push_back(host_weight);
      sent++;
    end
  endtask

  // Inputs change 1 time unit after the rising edge; this advances one full clock.
  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    rst_applied = !rst;
    #1;
    cyc++;
  endtask

  // mode 0: continuous, 1: valid every third cycle, 2: continuous plus a stray start at beat 20
  task automatic send_tile(input int mode, input int stop_iss);
    int k = 0;
    while (sent < TILE_SIZE && n_vld_tile < stop_iss && k < 1000) begin
      host_valid  = (mode == 1) ? (k % 3 == 0) : 1'b1;
      host_weight = wdata(sent);
      start       = (mode == 2 && sent == 20);
      cycle();
      k++;
    end
    if (k >= 1000) chk("send_timeout", sent, TILE_SIZE);
    host_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic wait_done(input logic hold_start);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < 100) begin
      start = hold_start;
      cycle();
      k++;
    end
    chk("done_seen", done_cnt - d0, 1);
    chk("done_latency", done_cyc - last_vld_cyc, DONE_DELAY + 1);
    chk("tile_count", n_vld_tile, TILE_SIZE);
    chk("sb_drained", sb_q.size(), 0);
  endtask

  task automatic begin_tile(input int mul, input int add);
    w_mul = mul;
    w_add = add;
    sent = 0;
    n_vld_tile = 0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  initial begin
    int d;
    @(posedge clk);
    #1;
    // Reset, then idle with no start
    rst = 1'b0;
    repeat (3) cycle();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("idle_outputs", 32'({host_ready, weight_valid, done, busy, weight, weight_addr}), 32'd0);
    end

    // Streaming tile, weight = addr + 1
    begin_tile(1, 1);
    send_tile(0, TILE_SIZE + 1);
    wait_done(1'b0);
    chk("busy_after_done", 32'(busy), 32'd0);
    repeat (4) cycle();
    chk("single_done", done_cnt, 1);
    chk("ready_idle", 32'(host_ready), 32'd0);

    // Host stalls produce bubbles
    begin_tile(3, 5);
    send_tile(1, TILE_SIZE + 1);
    wait_done(1'b0);

    // FIFO fills while issue is held off
    begin_tile(7, 8'h21);
    force dut.pop = 1'b0;
    host_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      host_weight = wdata(sent);
      cycle();
    end
    chk("full_accepts", sent, FIFO_DEPTH);
    chk("full_ready", 32'(host_ready), 32'd0);
    chk("full_no_issue", n_vld_tile, 0);
    release dut.pop;
    send_tile(0, TILE_SIZE + 1);
    wait_done(1'b0);

    // Reset after 30 issued weights abandons the tile
    begin_tile(1, 8'h40);
    send_tile(0, 30);
    d = done_cnt;
    rst = 1'b0;
    cycle();
    chk("rst_mid_valid", 32'(weight_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_ready", 32'(host_ready), 32'd0);
    rst = 1'b1;
    repeat (5) cycle();
    chk("rst_mid_no_done", done_cnt, d);

    // Fresh tile with a stray start during LOAD; start held through done
    begin_tile(5, 3);
    send_tile(2, TILE_SIZE + 1);
    wait_done(1'b1);
    chk("start_on_done_ignored", 32'(busy), 32'd0);

    // Back-to-back: start one cycle after done
    w_mul = 9;
    w_add = 2;
    sent = 0;
    n_vld_tile = 0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    send_tile(0, TILE_SIZE + 1);
    wait_done(1'b0);
    repeat (4) cycle();
    chk("final_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/weight_preload_sequencer.md
Name: weight_preload_sequencer

Overview:
Upstream feeder for the pre-load stage of the 8x8 systolic array. It accepts a 64-weight tile from the host over a valid/ready stream and buffers it in a small FIFO. It issues each weight with its linear weight-memory address (0..63) to the pre-load unit's Weight / Weight_Mem_Address_in inputs, then asserts the pre-load unit's done input once the last weight has cleared the WPU pipeline.

Parameters:
ARRAY_N, 8, systolic array dimension; tile = ARRAY_N*ARRAY_N weights
WEIGHT_W, 8, weight width in bits
ADDR_W, 6, address width; must equal clog2(ARRAY_N*ARRAY_N)
FIFO_DEPTH, 4, input buffer depth in entries; power of two, >= 2
DONE_DELAY, 2, cycles from last weight issue to done pulse; covers WPU latency

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-low: sampled low at a rising edge of clk clears all state
start  in  1  one-cycle pulse; begins a tile load; honoured only in IDLE
host_valid  in  1  host weight beat valid
host_weight  in  WEIGHT_W  host weight data
host_ready  out  1  sequencer accepts a beat this cycle
weight  out  WEIGHT_W  weight to pre-load unit (Weight)
weight_addr  out  ADDR_W  weight-memory address (Weight_Mem_Address_in)
weight_valid  out  1  weight/weight_addr are a new entry this cycle
done  out  1  one-cycle pulse; tile complete (drives pre-load done)
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst==0 at edge): state=IDLE; FIFO empty; accept/issue counters=0; weight=0, weight_addr=0, weight_valid=0, done=0, busy=0, host_ready=0.
- States: IDLE -> LOAD on start. LOAD -> DRAIN when the accept count reaches ARRAY_N*ARRAY_N. DRAIN -> WAIT when the issue count reaches ARRAY_N*ARRAY_N. WAIT counts DONE_DELAY cycles, then asserts done for exactly one cycle and returns to IDLE. done is registered and coincides with the transition to IDLE.
- The LOAD -> DRAIN check takes priority. If the 64th accept and the 64th issue land on the same edge, the block still passes through DRAIN for one cycle.
- start outside IDLE is ignored. A start in the same cycle done is high is ignored; start is accepted from the next cycle.
- host_ready = (state==LOAD) && !fifo_full && accept_cnt < 64. It is combinational from registered state only; no path from host_valid to host_ready. A beat is accepted on an edge with host_valid && host_ready.
- Host beats outside LOAD are not accepted. After the 64th beat host_ready drops the following cycle.
- FIFO: push on accept; pop when nonempty and state is LOAD or DRAIN. Push and pop on the same edge leave the occupancy unchanged. Push is impossible when full. No bypass path.
- Output register loads on a pop edge:
  - weight = popped data
  - weight_addr = issue_cnt[ADDR_W-1:0]
  - weight_valid = 1
  - issue_cnt increments
- On an edge with no pop: weight_valid = 0; weight and weight_addr hold their last values.
- Latency: a beat accepted into an empty FIFO at edge k is popped at edge k+1 and is visible with weight_valid high in the cycle after edge k+1. Steady-state throughput is one weight per cycle.
- Addresses are issued in strict order 0,1,...,63 with no gaps. Host stalls produce weight_valid=0 bubbles; the address does not advance during a bubble.
- Counters are ADDR_W+1 bits wide so the value 64 is representable. Both counters clear on entry to LOAD.
- Reset mid-operation abandons the tile. FIFO contents are discarded and done is not issued.
- Back-to-back tiles: a new start is accepted in IDLE immediately after done; addresses restart at 0.

Decomposition:
- Shared package: ARRAY_N, WEIGHT_W, ADDR_W, tile size constant (ARRAY_N*ARRAY_N), and the state enum (IDLE, LOAD, DRAIN, WAIT) encoded in 2 bits.
- One sub-module, preload_fifo: synchronous FIFO of width WEIGHT_W and depth FIFO_DEPTH, with push/pop/full/empty and the same active-low synchronous rst.

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles, release, no start -> all outputs 0, host_ready=0 for 20 cycles.
- Streaming tile: start, host_valid held high, host_weight=addr+1 -> 64 weight_valid cycles, weight_addr 0..63, weight=1..64; done pulses exactly once, DONE_DELAY+1 cycles after the last weight_valid (weight_addr=63); busy then falls.
- Host stalls: host_valid toggles 1,0,0,1,... -> weight_valid bubbles; weight_addr never skips or repeats; weight holds during bubbles; done after the 64th weight.
- FIFO full: host supplies 64 beats in a burst and pop is disabled via forced stall -> host_ready=0 after 4 accepts; no beat lost or duplicated; data order preserved.
- Reset mid-tile: rst=0 after 30 issued weights -> next cycle weight_valid=0, busy=0, done=0. A fresh start reissues from address 0.
- Ignored start / back-to-back: start pulsed during LOAD has no effect (address continuity kept). A start one cycle after done begins a second tile at address 0 with correct data.
